// File: rtl/mips_next_pc.sv
// ----------------------------------------------------------------------------
// mips_next_pc
// Program-counter / next-PC stage of the single-cycle MIPS core.
// Holds the PC register and selects the next PC each cycle from the decoder's
// branch/jump/syscall controls. Provides the jal link value (pc + 4), a
// RUN/HALT machine for halting syscalls, and saturating statistics counters.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_go                one-cycle pulse, resumes from HALT
//   i_beq/i_bne/i_bgez  conditional branch controls
//   i_jr/i_jmp/i_jal    jump controls (jr also asserts jmp)
//   i_syscall           syscall control
//   i_alu_equal         rs == rt
//   i_rs_data           rs value (jr target, bgez sign)
//   i_v0_data           $v0 value (syscall code)
//   i_imm16             instr[15:0]
//   i_instr_index       instr[25:0]
//   o_pc                current PC
//   o_pc_plus4          pc + 4 (jal link value)
//   o_halted            1 while in HALT
//   o_align_err         sticky misaligned-jr flag
//   o_cyc_cnt           RUN cycles
//   o_jmp_cnt           unconditional jumps executed
//   o_br_taken          conditional branches taken
//   o_br_ntaken         conditional branches not taken
// ----------------------------------------------------------------------------
module mips_next_pc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    input  logic             i_beq,
    input  logic             i_bne,
    input  logic             i_bgez,
    input  logic             i_jr,
    input  logic             i_jmp,
    input  logic             i_jal,
    input  logic             i_syscall,
    input  logic             i_alu_equal,
    input  logic [31:0]      i_rs_data,
    input  logic [31:0]      i_v0_data,
    input  logic [15:0]      i_imm16,
    input  logic [25:0]      i_instr_index,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc_plus4,
    output logic             o_halted,
    output logic             o_align_err,
    output logic [CNT_W-1:0] o_cyc_cnt,
    output logic [CNT_W-1:0] o_jmp_cnt,
    output logic [CNT_W-1:0] o_br_taken,
    output logic [CNT_W-1:0] o_br_ntaken
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic             r_align_err;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_jmp_cnt;
    logic [CNT_W-1:0] r_br_taken;
    logic [CNT_W-1:0] r_br_ntaken;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_target;
    logic [31:0]      w_jmp_target;
    logic [31:0]      w_pc_next;
    logic             w_any_jump;
    logic             w_any_cond;
    logic             w_taken;
    logic             w_halt_req;
    logic             w_run;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + CNT_ONE;
    endfunction

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_target  = w_pc_plus4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_jmp_target = {w_pc_plus4[31:28], i_instr_index, 2'b00};

    // Multiple conditional flags are illegal but resolve as an OR of taken terms.
    assign w_taken    = (i_beq & i_alu_equal) | (i_bne & ~i_alu_equal) | (i_bgez & ~i_rs_data[31]);
    assign w_any_cond = i_beq | i_bne | i_bgez;
    assign w_any_jump = i_jr | i_jmp;
    assign w_halt_req = i_syscall & (i_v0_data == HALT_CODE);
    assign w_run      = (r_state == ST_RUN);

    // Next-PC and next-state selection; a halting syscall falls through to pc+4.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = w_pc_plus4;
        case (r_state)
            ST_RUN: begin
                if (w_halt_req) begin
                    w_state_next = ST_HALT;
                    w_pc_next    = w_pc_plus4;
                end else if (i_jr) begin
                    w_pc_next = {i_rs_data[31:2], 2'b00};
                end else if (i_jmp) begin
                    w_pc_next = w_jmp_target;
                end else if (w_taken) begin
                    w_pc_next = w_br_target;
                end
            end
            ST_HALT: begin
                w_pc_next = r_pc;
                if (i_go) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_align_err <= 1'b0;
            r_cyc_cnt   <= '0;
            r_jmp_cnt   <= '0;
            r_br_taken  <= '0;
            r_br_ntaken <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_run) begin
                r_cyc_cnt <= sat_inc(r_cyc_cnt);
                if (!w_halt_req && i_jr && (i_rs_data[1:0] != 2'b00)) begin
                    r_align_err <= 1'b1;
                end
                if (w_any_jump) begin
                    r_jmp_cnt <= sat_inc(r_jmp_cnt);
                end else if (w_any_cond) begin
                    if (w_taken) begin
                        r_br_taken <= sat_inc(r_br_taken);
                    end else begin
                        r_br_ntaken <= sat_inc(r_br_ntaken);
                    end
                end
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_plus4  = w_pc_plus4;
    assign o_halted    = (r_state == ST_HALT);
    assign o_align_err = r_align_err;
    assign o_cyc_cnt   = r_cyc_cnt;
    assign o_jmp_cnt   = r_jmp_cnt;
    assign o_br_taken  = r_br_taken;
    assign o_br_ntaken = r_br_ntaken;

endmodule

// File: tb/tb_mips_next_pc.sv
module tb_mips_next_pc;

    logic        clk;
    logic        rst;
    logic        go;
    logic        beq, bne, bgez, jr, jmp, jal, syscall, alu_equal;
    logic [31:0] rs_data, v0_data;
    logic [15:0] imm16;
    logic [25:0] instr_index;

    logic [31:0] pc, pc_plus4;
    logic        halted, align_err;
    logic [31:0] cyc_cnt, jmp_cnt, br_taken, br_ntaken;

    logic [31:0] s_pc, s_pc_plus4;
    logic        s_halted, s_align_err;
    logic [3:0]  s_cyc_cnt, s_jmp_cnt, s_br_taken, s_br_ntaken;

    int checks = 0;
    int errors = 0;

    mips_next_pc #(.RESET_PC(32'h0), .HALT_CODE(32'd10), .CNT_W(32)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_go(go),
        .i_beq(beq), .i_bne(bne), .i_bgez(bgez),
        .i_jr(jr), .i_jmp(jmp), .i_jal(jal), .i_syscall(syscall),
        .i_alu_equal(alu_equal), .i_rs_data(rs_data), .i_v0_data(v0_data),
        .i_imm16(imm16), .i_instr_index(instr_index),
        .o_pc(pc), .o_pc_plus4(pc_plus4), .o_halted(halted), .o_align_err(align_err),
        .o_cyc_cnt(cyc_cnt), .o_jmp_cnt(jmp_cnt), .o_br_taken(br_taken), .o_br_ntaken(br_ntaken)
    );

    // Narrow-counter instance sharing the same stimulus, to reach saturation quickly.
    mips_next_pc #(.RESET_PC(32'h0), .HALT_CODE(32'd10), .CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_go(go),
        .i_beq(beq), .i_bne(bne), .i_bgez(bgez),
        .i_jr(jr), .i_jmp(jmp), .i_jal(jal), .i_syscall(syscall),
        .i_alu_equal(alu_equal), .i_rs_data(rs_data), .i_v0_data(v0_data),
        .i_imm16(imm16), .i_instr_index(instr_index),
        .o_pc(s_pc), .o_pc_plus4(s_pc_plus4), .o_halted(s_halted), .o_align_err(s_align_err),
        .o_cyc_cnt(s_cyc_cnt), .o_jmp_cnt(s_jmp_cnt), .o_br_taken(s_br_taken), .o_br_ntaken(s_br_ntaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        go = 0; beq = 0; bne = 0; bgez = 0; jr = 0; jmp = 0; jal = 0; syscall = 0;
        alu_equal = 0; rs_data = 0; v0_data = 0; imm16 = 0; instr_index = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear_ctl();
        rst = 1;
        step();
        rst = 0;
        // reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_align", align_err, 1'b0);
        chk("rst_cyc", cyc_cnt, 0);
        chk("rst_jmp", jmp_cnt, 0);
        chk("rst_brt", br_taken, 0);
        chk("rst_brn", br_ntaken, 0);
        chk("rst_pc4", pc_plus4, 32'h4);

        // three plain cycles
        step(); step(); step();
        chk("plain_pc", pc, 32'h0C);
        chk("plain_cyc", cyc_cnt, 3);
        step();
        chk("plain_pc10", pc, 32'h10);

        // beq taken backwards: 0x14 - 16 = 0x04
        beq = 1; alu_equal = 1; imm16 = 16'hFFFC;
        step();
        clear_ctl();
        chk("beq_t_pc", pc, 32'h04);
        chk("beq_t_cnt", br_taken, 1);
        chk("beq_t_ncnt", br_ntaken, 0);
        step(); step(); step();
        chk("back_pc10", pc, 32'h10);

        // beq not taken
        beq = 1; alu_equal = 0; imm16 = 16'hFFFC;
        step();
        clear_ctl();
        chk("beq_nt_pc", pc, 32'h14);
        chk("beq_nt_cnt", br_ntaken, 1);
        chk("beq_nt_tcnt", br_taken, 1);
        step(); step(); step();
        chk("pc20", pc, 32'h20);

        // jal
        jal = 1; jmp = 1; instr_index = 26'h40;
        #1;
        chk("jal_pc4", pc_plus4, 32'h24);
        step();
        clear_ctl();
        chk("jal_pc", pc, 32'h100);
        chk("jal_cnt", jmp_cnt, 1);
        chk("cyc13", cyc_cnt, 13);

        // jr beats beq; misaligned target
        jr = 1; jmp = 1; beq = 1; alu_equal = 1; rs_data = 32'h203; imm16 = 16'h0100;
        step();
        clear_ctl();
        chk("jr_pc", pc, 32'h200);
        chk("jr_align", align_err, 1'b1);
        chk("jr_brt", br_taken, 1);
        chk("jr_brn", br_ntaken, 1);
        chk("jr_jcnt", jmp_cnt, 2);
        step();
        chk("sticky_pc", pc, 32'h204);
        chk("sticky_align", align_err, 1'b1);

        // bgez taken on non-negative rs, then not taken on negative rs
        bgez = 1; rs_data = 32'h0000_0005; imm16 = 16'h0003;
        step();
        clear_ctl();
        chk("bgez_t_pc", pc, 32'h214);
        bgez = 1; rs_data = 32'h8000_0000; imm16 = 16'h0003;
        step();
        clear_ctl();
        chk("bgez_nt_pc", pc, 32'h218);
        chk("bgez_brt", br_taken, 2);
        chk("bgez_brn", br_ntaken, 2);

        // j to 0x30
        jmp = 1; instr_index = 26'h0C;
        step();
        clear_ctl();
        chk("j_pc30", pc, 32'h30);
        chk("j_cnt", jmp_cnt, 3);
        chk("cyc18", cyc_cnt, 18);

        // halting syscall
        syscall = 1; v0_data = 32'd10;
        step();
        clear_ctl();
        chk("halt_pc", pc, 32'h34);
        chk("halt_flag", halted, 1'b1);
        chk("halt_cyc", cyc_cnt, 19);
        chk("sat_cyc", s_cyc_cnt, 4'hF);

        // controls ignored while halted
        jmp = 1; instr_index = 26'h0; beq = 1; alu_equal = 1;
        step(); step(); step(); step(); step();
        clear_ctl();
        chk("hold_pc", pc, 32'h34);
        chk("hold_cyc", cyc_cnt, 19);
        chk("hold_jmp", jmp_cnt, 3);
        chk("hold_halted", halted, 1'b1);

        // resume
        go = 1;
        step();
        go = 0;
        chk("go_halted", halted, 1'b0);
        chk("go_pc", pc, 32'h34);
        step();
        chk("resume_pc", pc, 32'h38);
        chk("resume_cyc", cyc_cnt, 20);

        // non-halting syscall
        syscall = 1; v0_data = 32'd1;
        step();
        clear_ctl();
        chk("sys1_pc", pc, 32'h3C);
        chk("sys1_halted", halted, 1'b0);

        // go in RUN ignored
        go = 1;
        step();
        go = 0;
        chk("go_run_pc", pc, 32'h40);
        chk("go_run_halted", halted, 1'b0);
        chk("sat_cyc2", s_cyc_cnt, 4'hF);

        // halt again, then reset while halted
        syscall = 1; v0_data = 32'd10;
        step();
        clear_ctl();
        chk("halt2_pc", pc, 32'h44);
        chk("halt2_flag", halted, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk("rsth_pc", pc, 32'h0);
        chk("rsth_halted", halted, 1'b0);
        chk("rsth_cyc", cyc_cnt, 0);
        chk("rsth_align", align_err, 1'b0);
        chk("rsth_sat", s_cyc_cnt, 4'h0);
        step();
        chk("rsth_run_pc", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
